// File: rtl/fifo_sync_mc.sv
// fifo_sync_mc: single-clock FIFO, FWFT or registered read,
// programmable watermarks, flush and overflow/underflow reporting.
//
// Ports:
//   clk, rst (sync, active-high), flush (sync clear)
//   din/wr_en            write side
//   rd_en                read request / FWFT pop
//   prog_full_thr        progfull when count >= thr
//   prog_empty_thr       progempty when count <= thr
//   dout/dout_valid      read data
//   empty/alempty/progempty, full/alfull/progfull
//   rd_count (count), wr_space (DEPTH - count)
//   overflow/underflow   1-cycle error pulses
//   err_sticky           held until rst or flush
module fifo_sync_mc #(
  parameter int DW   = 8,
  parameter int AW   = 8,
  parameter bit FWFT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [DW-1:0] din,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [AW:0]   prog_full_thr,
  input  logic [AW:0]   prog_empty_thr,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          empty,
  output logic          alempty,
  output logic          progempty,
  output logic          full,
  output logic          alfull,
  output logic          progfull,
  output logic [AW:0]   rd_count,
  output logic [AW:0]   wr_space,
  output logic          overflow,
  output logic          underflow,
  output logic          err_sticky
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] DEPTH_V = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_p;
  logic [AW:0]   rd_p;
  logic [AW:0]   count;
  logic          clr;
  logic          wr_acc;
  logic          rd_acc;
  logic          ovf_n;
  logic          unf_n;
  logic [DW-1:0] rd_word;

  // Extra pointer bit separates full from empty.
  assign count     = wr_p - rd_p;
  assign rd_count  = count;
  assign wr_space  = DEPTH_V - count;
  assign empty     = (count == '0);
  assign alempty   = (count <= ONE);
  assign full      = (count == DEPTH_V);
  assign alfull    = (count >= (DEPTH_V - ONE));
  assign progfull  = (count >= prog_full_thr);
  assign progempty = (count <= prog_empty_thr);

  assign clr     = rst | flush;
  assign wr_acc  = wr_en & ~full & ~clr;
  assign rd_acc  = rd_en & ~empty & ~clr;
  assign ovf_n   = wr_en & full;
  assign unf_n   = rd_en & empty;
  assign rd_word = mem[rd_p[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_p[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_p       <= '0;
      rd_p       <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (wr_acc) wr_p <= wr_p + ONE;
      if (rd_acc) rd_p <= rd_p + ONE;
      overflow   <= ovf_n;
      underflow  <= unf_n;
      err_sticky <= err_sticky | ovf_n | unf_n;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign dout       = empty ? '0 : rd_word;
      assign dout_valid = ~empty;
    end else begin : g_std
      logic [DW-1:0] dout_q;
      logic          dv_q;

      always_ff @(posedge clk) begin
        if (clr) begin
          dout_q <= '0;
          dv_q   <= 1'b0;
        end else begin
          dv_q <= rd_acc;
          if (rd_acc) dout_q <= rd_word;
        end
      end

      assign dout       = dout_q;
      assign dout_valid = dv_q;
    end
  endgenerate

endmodule

// File: doc/fifo_sync_mc.md
Name: fifo_sync_mc

Overview:
- Next-generation single-clock synchronous FIFO for intra-domain buffering.
- Adds over the previous generation:
  - compile-time read mode selection: FWFT or standard registered read.
  - runtime-programmable full/empty watermarks.
  - same-cycle-accurate flags, with no pointer delay stages.
  - synchronous flush.
  - overflow/underflow pulse and sticky error reporting.
- Sits between producer/consumer stages inside one clock domain.

Parameters:
- DW, 8, data width in bits (>=1).
- AW, 8, address width; DEPTH = 2**AW entries (AW>=1).
- FWFT, 1, 1 = first-word-fall-through read; 0 = standard read with 1-cycle latency.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous clear of FIFO contents and sticky errors.
- din  in  DW  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request / FWFT pop.
- prog_full_thr  in  AW+1  progfull watermark (entries).
- prog_empty_thr  in  AW+1  progempty watermark (entries).
- dout  out  DW  read data.
- dout_valid  out  1  dout holds valid data.
- empty  out  1  count == 0.
- alempty  out  1  count <= 1.
- progempty  out  1  count <= prog_empty_thr.
- full  out  1  count == DEPTH.
- alfull  out  1  count >= DEPTH-1.
- progfull  out  1  count >= prog_full_thr.
- rd_count  out  AW+1  entries stored (count).
- wr_space  out  AW+1  DEPTH - count.
- overflow  out  1  one-cycle pulse: write attempted while full.
- underflow  out  1  one-cycle pulse: read attempted while empty.
- err_sticky  out  1  set by any overflow/underflow; cleared only by rst or flush.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high, sampled on the rising edge of clk.
- Priority: rst > flush > normal operation. wr_en and rd_en are ignored in a rst or flush cycle.
- Pointers: wr_p and rd_p are AW+1 bits and wrap modulo 2**(AW+1).
  - count = wr_p - rd_p (AW+1-bit arithmetic), range 0..DEPTH.
  - All flags, rd_count and wr_space decode combinationally from the registered pointers. They reflect accepted operations the cycle after the accepting edge.
- Accept rules:
  - Write is accepted iff wr_en && !full.
  - Read is accepted iff rd_en && !empty.
  - Flags are evaluated on pre-edge state, so:
    - Simultaneous rd+wr when full: read accepted, write rejected (overflow pulses).
    - Simultaneous rd+wr when empty: write accepted, read rejected (underflow pulses).
  - Simultaneous rd+wr otherwise: both accepted, count unchanged.
- Memory: DW x DEPTH array, not reset. Write stores din at wr_p[AW-1:0].
- FWFT=1 read:
  - dout = mem[rd_p[AW-1:0]] when !empty, else all zeros.
  - dout_valid = !empty.
  - First word is visible the cycle after its write is accepted.
  - rd_en pops the current word.
- FWFT=0 read:
  - An accepted read registers mem[rd_p] into dout at that edge; dout_valid=1 for exactly the following cycle.
  - dout holds its last value when no read is accepted. dout_valid=0 otherwise.
- Error reporting:
  - overflow and underflow are registered, high for one cycle after the offending edge.
  - err_sticky sets on the same edge as either pulse.
- Reset/flush values:
  - Pointers 0, dout 0, dout_valid 0, overflow 0, underflow 0, err_sticky 0.
  - Hence empty=1, alempty=1, full=0, alfull=0, rd_count=0, wr_space=DEPTH.
  - progempty=1 always after reset/flush (0 <= thr).
  - progfull = (prog_full_thr == 0).
- Watermarks:
  - prog_full_thr and prog_empty_thr may change at any time; the flags follow combinationally.
  - prog_full_thr > DEPTH makes progfull never assert.
- Mid-operation: rst or flush in any cycle discards all contents immediately. Reads the next cycle see empty.

Test Plan:
- Reset, AW=2, FWFT=1: rst 1 cycle ->
  - empty=1, alempty=1, full=0, rd_count=0, wr_space=4, dout=0, err_sticky=0.
- Fill and drain, AW=2, FWFT=1:
  - Write 0x11,0x22,0x33,0x44 on 4 consecutive cycles -> full=1 and alfull=1 after 4th edge, rd_count=4, dout=0x11.
  - Pop 4 -> dout sequence 0x11,0x22,0x33,0x44, then empty=1.
- Standard mode, FWFT=0: write 0xA5, then rd_en 1 cycle -> dout=0xA5 with dout_valid=1 exactly one cycle after the read edge; dout stays 0xA5 afterwards with dout_valid=0.
- Boundary collisions, AW=2:
  - Full + wr_en + rd_en -> rd_count 3, overflow pulse 1 cycle, err_sticky=1.
  - Empty + wr_en + rd_en -> rd_count 1, underflow pulse, data intact.
- Watermarks: prog_full_thr=3, prog_empty_thr=1.
  - Write 3 words -> progfull asserts after 3rd edge, progempty deasserts after 2nd edge.
  - Change prog_full_thr to 4 -> progfull drops same cycle.
- Flush/pointer wrap:
  - Run 3*DEPTH mixed ops -> checked against a reference queue.
  - flush asserted with 2 entries plus wr_en=1 -> next cycle empty=1, rd_count=0, err_sticky=0, write ignored.
